// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared CPU constants and control-unit state encodings
package risc_pkg;

  localparam int PC_WIDTH  = 8;
  localparam int RAS_DEPTH = 8;

  // Control-unit state codes, shared with the bench and neighbouring blocks
  typedef enum logic [2:0] {
    RESET_STATE = 3'b000,
    FETCH_INSTR = 3'b001,
    READ_OPS    = 3'b010,
    EXECUTE     = 3'b011,
    WRITEBACK   = 3'b100
  } cpu_state_t;

endpackage

// File: rtl/risc_pc_stack_if.sv
// rtl/risc_pc_stack_if.sv - control-unit to return-address-stack signal bundle
interface risc_pc_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);

  logic                     PushEnbl;
  logic                     PopEnbl;
  logic [WIDTH-1:0]         Push_Data;
  logic                     Clr_Err;
  logic [WIDTH-1:0]         Pop_Data;
  logic                     Pop_Valid;
  logic [WIDTH-1:0]         Top_Of_Stack;
  logic [$clog2(DEPTH):0]   Stack_Level;
  logic                     Stack_Full;
  logic                     Stack_Empty;
  logic                     Overflow_Err;
  logic                     Underflow_Err;

  modport master (
    output PushEnbl, PopEnbl, Push_Data, Clr_Err,
    input  Pop_Data, Pop_Valid, Top_Of_Stack, Stack_Level,
    input  Stack_Full, Stack_Empty, Overflow_Err, Underflow_Err
  );

  modport slave (
    input  PushEnbl, PopEnbl, Push_Data, Clr_Err,
    output Pop_Data, Pop_Valid, Top_Of_Stack, Stack_Level,
    output Stack_Full, Stack_Empty, Overflow_Err, Underflow_Err
  );

endinterface

// File: rtl/ras_ptr_ctrl.sv
// rtl/ras_ptr_ctrl.sv - stack pointer/level counter with full, empty and sticky error logic
module ras_ptr_ctrl #(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] top_idx,
  output logic          pop_ok
);

  logic ovf_set;
  logic unf_set;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A push+pop pair replaces the top entry, so it is accepted even when full
  always_comb begin
    pop_ok  = pop && !empty;
    wr_en   = push && (!full || pop);
    top_idx = AW'(level - LW'(1));
    wr_idx  = pop_ok ? top_idx : level[AW-1:0];
    ovf_set = push && !pop && full;
    unf_set = pop && empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en && !pop_ok)
        level <= level + LW'(1);
      else if (pop_ok && !wr_en)
        level <= level - LW'(1);
      // A fresh error in the clearing cycle keeps the flag set
      overflow_err  <= ovf_set || (overflow_err  && !clr_err);
      underflow_err <= unf_set || (underflow_err && !clr_err);
    end
  end

endmodule

// File: rtl/risc_pc_stack.sv
// rtl/risc_pc_stack.sv - hardware return-address stack fed by control-unit push/pop strobes
module risc_pc_stack
  import risc_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = PC_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  risc_pc_stack_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pop_data_q;
  logic             pop_valid_q;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             unf_err;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             pop_ok;

  ras_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk           (clk),
    .reset_n       (reset_n),
    .push          (bus.PushEnbl),
    .pop           (bus.PopEnbl),
    .clr_err       (bus.Clr_Err),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overflow_err  (ovf_err),
    .underflow_err (unf_err),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .top_idx       (top_idx),
    .pop_ok        (pop_ok)
  );

  // Array is deliberately not reset; gating on reset_n drops a write caught by reset
  always_ff @(posedge clk) begin
    if (reset_n && wr_en)
      mem[wr_idx] <= bus.Push_Data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_ok;
      if (pop_ok)
        pop_data_q <= mem[top_idx];
    end
  end

  assign bus.Pop_Data      = pop_data_q;
  assign bus.Pop_Valid     = pop_valid_q;
  assign bus.Top_Of_Stack  = empty ? '0 : mem[top_idx];
  assign bus.Stack_Level   = level;
  assign bus.Stack_Full    = full;
  assign bus.Stack_Empty   = empty;
  assign bus.Overflow_Err  = ovf_err;
  assign bus.Underflow_Err = unf_err;

endmodule
